// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit stages.
// The 27 MHz / 115200 baud link gives 234 clocks per bit.
package uart_pkg;

    localparam int unsigned FREQ         = 27_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned CLKS_PER_BIT = FREQ / BAUD;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
// Both flops reset to RESET_VAL so an idle-high line reads idle from reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so r_sync takes the old r_meta.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, byte handed
// out on a valid/ready interface, framing errors and overruns pulsed for one cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FREQ = uart_pkg::FREQ,
    parameter int unsigned BAUD = uart_pkg::BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = FREQ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT     = 16'(HALF - 1);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic        w_rx_s;
    logic [15:0] r_bit_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_cnt_clr;
    logic        w_shift;
    logic        w_stop_hit;
    logic        w_deliver;
    logic        w_frame_bad;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_stop_hit  = 1'b0;
        unique case (r_state)
            IDLE: if (!w_rx_s) begin
                w_state_nxt = START;
                w_cnt_clr   = 1'b1;
            end
            START: if (r_bit_cnt == HALF_CNT) begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = w_rx_s ? IDLE : DATA;
            end
            DATA: if (r_bit_cnt == LAST_CNT) begin
                w_cnt_clr = 1'b1;
                w_shift   = 1'b1;
                if (r_bit_idx == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (r_bit_cnt == LAST_CNT) begin
                w_cnt_clr   = 1'b1;
                w_stop_hit  = 1'b1;
                w_state_nxt = w_rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: if (w_rx_s) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_deliver   = w_stop_hit & w_rx_s;
    assign w_frame_bad = w_stop_hit & ~w_rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            if (w_cnt_clr)
                r_bit_cnt <= '0;
            else if (r_state inside {START, DATA, STOP})
                r_bit_cnt <= r_bit_cnt + 16'd1;

            if (r_state == START)
                r_bit_idx <= '0;
            else if (w_shift)
                r_bit_idx <= r_bit_idx + 3'd1;

            if (w_shift) r_shreg <= {w_rx_s, r_shreg[7:1]};
        end
    end

    // A consume and a delivery on the same edge hand over the new byte without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_deliver & r_rx_valid & ~rx_ready;
            if (w_deliver && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame table plus hand-written corner
// sequences, with a scoreboard queue checked at every valid/ready transfer.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0_cyc   = 0;
    int valid_rise_cyc = -1;
    int n_xfer = 0, n_valid_cyc = 0, n_ferr = 0, n_ovr = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    // Receiver-side stop-sample offset from E0 is 2226 (E3+HALF+9*234); the
    // window allows for where exactly the synchronizer latency is counted.
    localparam int LAT_LO = 2224;
    localparam int LAT_HI = 2229;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: a transfer happens on the next edge whenever valid && ready.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) n_valid_cyc++;
            if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (rx_valid && rx_ready) begin
                n_xfer++;
                check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("xfer_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = rx_valid;
    end

    // All line drivers start and end #1 after a rising edge.
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop_b);
        e0_cyc = cyc + 1;
        hold(1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(d[i], cpb);
        hold(stop_b, cpb);
    endtask

    typedef struct {
        logic [7:0] data;
        int         cpb;
        logic       stop_b;
        int         idle_after;
        logic       exp_ok;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, v0, f0, o0, fall;

        vecs[0] = '{8'h41, 234, 1'b1, 0,  1'b1};
        vecs[1] = '{8'h55, 235, 1'b1, 0,  1'b1};
        vecs[2] = '{8'hAA, 235, 1'b1, 0,  1'b1};
        vecs[3] = '{8'h00, 233, 1'b1, 0,  1'b1};
        vecs[4] = '{8'hFF, 234, 1'b1, 0,  1'b1};
        vecs[5] = '{8'hC3, 234, 1'b0, 20, 1'b0};
        vecs[6] = '{8'hA5, 234, 1'b1, 5,  1'b1};

        rst = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        hold(1'b1, 5);

        // Frame table, sent back to back with the consumer always ready.
        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            x0 = n_xfer; v0 = n_valid_cyc; f0 = n_ferr;
            if (vecs[i].exp_ok) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].cpb, vecs[i].stop_b);
            if (vecs[i].idle_after > 0) hold(1'b1, vecs[i].idle_after);
            if (vecs[i].exp_ok) begin
                check("vec_xfer_count", 32'(n_xfer - x0), 32'd1);
                check("vec_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
                check_range("vec_latency", valid_rise_cyc - e0_cyc, LAT_LO, LAT_HI);
                check("vec_frame_err", 32'(n_ferr - f0), 32'd0);
            end else begin
                check("vec_err_no_xfer", 32'(n_xfer - x0), 32'd0);
                check("vec_err_frame_err", 32'(n_ferr - f0), 32'd1);
            end
        end
        hold(1'b1, 20);
        check("table_overrun", 32'(n_ovr), 32'd0);

        // Start-bit glitch: 50 low cycles must be rejected at the start sample.
        x0 = n_xfer; f0 = n_ferr; fall = -100000;
        e0_cyc = cyc + 1;
        hold(1'b0, 50);
        check("glitch_busy_mid", 32'(busy), 32'd1);
        rx = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                fall = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        check_range("glitch_busy_fall", fall - e0_cyc, 117, 122);
        hold(1'b1, 20);
        check("glitch_no_xfer", 32'(n_xfer - x0), 32'd0);
        check("glitch_no_frame_err", 32'(n_ferr - f0), 32'd0);

        // Broken stop bit followed by a long break, then a good frame.
        x0 = n_xfer; f0 = n_ferr;
        send_frame(8'h3C, 234, 1'b0);
        hold(1'b0, 1500);
        check("break_busy", 32'(busy), 32'd1);
        check("break_frame_err", 32'(n_ferr - f0), 32'd1);
        hold(1'b0, 1500);
        hold(1'b1, 20);
        check("break_idle", 32'(busy), 32'd0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 234, 1'b1);
        hold(1'b1, 10);
        check("break_xfer_count", 32'(n_xfer - x0), 32'd1);
        check("break_frame_err_total", 32'(n_ferr - f0), 32'd1);

        // Overrun: consumer stalled across two frames.
        rx_ready = 1'b0;
        x0 = n_xfer; o0 = n_ovr;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 234, 1'b1);
        send_frame(8'h42, 234, 1'b1);
        hold(1'b1, 10);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h41);
        check("ovr_pulse", 32'(n_ovr - o0), 32'd1);
        check("ovr_no_xfer", 32'(n_xfer - x0), 32'd0);
        rx_ready = 1'b1;
        hold(1'b1, 1);
        rx_ready = 1'b0;
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        check("ovr_xfer", 32'(n_xfer - x0), 32'd1);

        // Reset mid-frame with a stale byte held.
        send_frame(8'h99, 234, 1'b1);
        hold(1'b1, 5);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_data", 32'(rx_data), 32'h99);
        hold(1'b0, 234);
        repeat (4) hold(1'b1, 234);
        hold(1'b1, 100);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #2;
        check("mid_rst_rx_data", 32'(rx_data), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        hold(1'b1, 10);
        rst = 1'b1;
        hold(1'b1, 300);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_no_valid", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        x0 = n_xfer;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 234, 1'b1);
        hold(1'b1, 10);
        check("post_rst_xfer", 32'(n_xfer - x0), 32'd1);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_frame_err_total", 32'(n_ferr), 32'd2);
        check("final_overrun_total", 32'(n_ovr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
